rhd_config_seq: RTL and testbench
=================================

# rhd_config_seq

Sequences the power-up register configuration of one RHD headstage through an rhd_spi_master: register writes, optional ADC calibration, then a chip-ID readback. It verifies every returned frame against the chip's two-frame pipeline echo. It runs before the recording sequencer takes the SPI master, and reports busy, done and a sticky error with the failing frame index.

## Interface
Parameters:
- NUM_REGS, 18: registers written, addresses 0..NUM_REGS-1 (1..63)
- CHIP_ID_EXPECT, 8'd4: expected content of register 63
- CAL_DUMMIES, 9: dummy commands after CALIBRATE

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle request; ignored unless IDLE
- cfg_abort  in  1  return to IDLE next cycle, no done
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at sequence end
- error  out  1  sticky mismatch flag; cleared on accepted cfg_start
- err_index  out  8  frame index of first mismatch
- chip_id  out  8  captured register-63 value
- tbl_addr  out  6  register address being fetched
- tbl_data  in  8  value for tbl_addr, combinational table
- spi_start  out  1  one-cycle frame start to SPI master
- spi_data_in  out  16  command word, stable from LOAD until spi_done
- spi_done  in  1  level, high after frame completes until next start
- spi_rx  in  16  frame result (a_data_out)

## Operation
- Command words: write {2'b10, addr, data}; read {2'b11, addr, 8'd0}; calibrate 16'h5500.
- Frame list, index f from 0:
  - f < NUM_REGS: write tbl_data to address f, expect kind ECHO.
  - If calibration is compiled in: one CALIBRATE (kind NONE), then CAL_DUMMIES reads of reg 63 (kind NONE).
  - One read of reg 63, kind ID.
  - Two flush reads of reg 63, kind NONE.
- States:
  - IDLE: on cfg_start go to LOAD, clear error/err_index, f = 0.
  - LOAD: drive spi_data_in. When spi_done == 0, go to TX.
  - TX: spi_start = 1 for one cycle, then go to WAIT.
  - WAIT: on spi_done == 1, check and advance. If f was the last frame, pulse done and go to IDLE; otherwise f++ and go to LOAD.
- Expectation pipeline: a 2-entry shift register of {kind, value}, pushed at each TX. The entry issued two frames earlier is checked against spi_rx in WAIT.
  - ECHO: require spi_rx == {8'hFF, value}.
  - ID: capture chip_id = spi_rx[7:0]; require spi_rx == {8'h00, CHIP_ID_EXPECT}.
  - NONE: no check.
- The first two frames check nothing; the pipeline is flushed empty at IDLE entry.
- First mismatch sets error and latches err_index = f - 2. Later mismatches do not overwrite it.
- The sequence always completes; an error never stops it.
- tbl_addr = f[5:0] during write frames, 0 otherwise.

## Timing
- Reset values: state IDLE, busy 0, done 0, error 0, err_index 0, chip_id 0, spi_start 0, spi_data_in 0, tbl_addr 0, pipeline empty.
- cfg_start in cycle n: busy = 1 at n+1. The earliest spi_start is at n+2, when spi_done is already low.
- Per-frame overhead is 3 cycles plus the SPI frame time.
- done and busy fall in the same cycle; done is high for exactly one cycle.
- cfg_start together with cfg_abort in IDLE: abort wins and start is ignored.
- cfg_abort in any non-IDLE state: IDLE next cycle, pipeline cleared, spi_start forced low. error and chip_id hold their values.
- Reset mid-frame: immediate return to reset values. The SPI master is reset by the same rstn.

## Configuration
- RHD_CAL_EN defined: CALIBRATE plus CAL_DUMMIES dummy frames are inserted after the writes. Total frames = NUM_REGS + CAL_DUMMIES + 4.
- RHD_CAL_EN undefined: no calibrate frames. Total frames = NUM_REGS + 3.

## Structure
- Shared package rhd_pkg holds:
  - command-encode functions (write, read, convert)
  - CMD_CALIBRATE = 16'h5500
  - INTAN_CHIP_ID_REG = 63
  - the expect-kind enum {NONE, ECHO, ID}
  - the state enum
- Sub-module rhd_expect_pipe: 2-deep {kind, value} shift register with push, clear and an output tap. It is reusable by the recording sequencer.

## Test plan
- NUM_REGS=3, RHD_CAL_EN undefined, bench SPI model echoes correctly, reg 63 = 4 -> 6 spi_start pulses, done once, error 0, chip_id 8'd4.
- Same, but register 1's echo is corrupted to 16'hFF00 while tbl_data was 8'h5A -> error 1, err_index 1, done still pulses after 6 frames.
- RHD_CAL_EN defined, NUM_REGS=18 -> 31 frames; frame 18 carries 16'h5500; frames 19..27 carry 16'hFF00.
- cfg_abort asserted in WAIT of frame 5 -> busy 0 next cycle, no done. A new cfg_start restarts at frame 0 with error cleared.
- cfg_start pulsed while busy, and rstn asserted mid-frame -> the start is ignored; on reset all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/rhd_pkg.sv
// rhd_pkg: command encodings, expectation kinds and sequencer state type
// shared by the RHD headstage sequencers.
package rhd_pkg;

  localparam logic [15:0] CMD_CALIBRATE     = 16'h5500;
  localparam logic [5:0]  INTAN_CHIP_ID_REG = 6'd63;

  // What a returned frame must look like, two frames after its command.
  typedef enum logic [1:0] {
    EXP_NONE = 2'd0,
    EXP_ECHO = 2'd1,
    EXP_ID   = 2'd2
  } exp_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_TX   = 2'd2,
    ST_WAIT = 2'd3
  } cfg_state_e;

  function automatic logic [15:0] cmd_write(input logic [5:0] addr, input logic [7:0] data);
    return {2'b10, addr, data};
  endfunction

  function automatic logic [15:0] cmd_read(input logic [5:0] addr);
    return {2'b11, addr, 8'd0};
  endfunction

  function automatic logic [15:0] cmd_convert(input logic [5:0] channel);
    return {2'b00, channel, 8'd0};
  endfunction

endpackage

// File: rtl/rhd_expect_pipe.sv
// rhd_expect_pipe: two-deep {kind, value} shift register tracking what the
// RHD chip owes us. The tap is the oldest entry, i.e. the frame issued two
// pushes ago; sampling it in the same cycle as a push yields the entry that
// belongs to the frame now being returned.
module rhd_expect_pipe
  import rhd_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       push,
  input  logic [1:0] push_kind,
  input  logic [7:0] push_value,
  output logic [1:0] tap_kind,
  output logic [7:0] tap_value
);

  logic [1:0] kind0_q, kind0_d, kind1_q, kind1_d;
  logic [7:0] val0_q, val0_d, val1_q, val1_d;

  // Next-state: clear empties both slots (clear dominates push), push shifts.
  always_comb begin
    kind0_d = kind0_q;
    kind1_d = kind1_q;
    val0_d  = val0_q;
    val1_d  = val1_q;
    if (clear) begin
      kind0_d = EXP_NONE;
      kind1_d = EXP_NONE;
      val0_d  = 8'd0;
      val1_d  = 8'd0;
    end else if (push) begin
      kind0_d = push_kind;
      val0_d  = push_value;
      kind1_d = kind0_q;
      val1_d  = val0_q;
    end
  end

  // Slot registers, empty after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      kind0_q <= EXP_NONE;
      kind1_q <= EXP_NONE;
      val0_q  <= 8'd0;
      val1_q  <= 8'd0;
    end else begin
      kind0_q <= kind0_d;
      kind1_q <= kind1_d;
      val0_q  <= val0_d;
      val1_q  <= val1_d;
    end
  end

  assign tap_kind  = kind1_q;
  assign tap_value = val1_q;

endmodule

// File: rtl/rhd_config_seq.sv
// rhd_config_seq: power-up register configuration of one RHD headstage via
// an rhd_spi_master. Writes NUM_REGS table registers, optionally calibrates
// (compile with RHD_CAL_EN), reads back the chip ID and checks every returned
// frame against the chip's two-frame echo.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for cfg_start
// LOAD    | command word registered, wait for SPI master to drop done
// TX      | one-cycle spi_start; capture expectation for returning frame
// WAIT    | wait for spi_done, check spi_rx, advance frame index
module rhd_config_seq
  import rhd_pkg::*;
#(
  parameter int         NUM_REGS       = 18,
  parameter logic [7:0] CHIP_ID_EXPECT = 8'd4,
  parameter int         CAL_DUMMIES    = 9
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_index,
  output logic [7:0]  chip_id,
  output logic [5:0]  tbl_addr,
  input  logic [7:0]  tbl_data,
  output logic        spi_start,
  output logic [15:0] spi_data_in,
  input  logic        spi_done,
  input  logic [15:0] spi_rx
);

`ifdef RHD_CAL_EN
  localparam int CAL_FRAMES = CAL_DUMMIES + 1;
`else
  localparam int CAL_FRAMES = 0;
`endif
  localparam int         NUM_FRAMES = NUM_REGS + CAL_FRAMES + 3;
  localparam logic [7:0] REGS_F     = 8'(NUM_REGS);
  localparam logic [7:0] ID_F       = 8'(NUM_REGS + CAL_FRAMES);
  localparam logic [7:0] LAST_F     = 8'(NUM_FRAMES - 1);

  cfg_state_e  state_q, state_d;
  logic [7:0]  f_q, f_d;
  logic        error_q, error_d;
  logic [7:0]  err_index_q, err_index_d;
  logic [7:0]  chip_id_q, chip_id_d;
  logic        spi_start_q, spi_start_d;
  logic [15:0] spi_data_q, spi_data_d;
  logic [1:0]  chk_kind_q, chk_kind_d;
  logic [7:0]  chk_value_q, chk_value_d;

  logic [15:0] frm_cmd;
  logic [1:0]  frm_kind;
  logic [7:0]  frm_value;
  logic        pipe_clear, pipe_push;
  logic [1:0]  tap_kind;
  logic [7:0]  tap_value;
  logic        check_en;
  logic [15:0] rx_expect;
  logic        rx_mismatch;
  logic        done_o;

  // Decode the current frame index into command word and expectation.
  always_comb begin
    frm_cmd   = cmd_read(INTAN_CHIP_ID_REG);
    frm_kind  = EXP_NONE;
    frm_value = 8'd0;
    if (f_q < REGS_F) begin
      frm_cmd   = cmd_write(f_q[5:0], tbl_data);
      frm_kind  = EXP_ECHO;
      frm_value = tbl_data;
    end
`ifdef RHD_CAL_EN
    else if (f_q == REGS_F) begin
      frm_cmd = CMD_CALIBRATE;
    end
`endif
    else if (f_q == ID_F) begin
      frm_kind  = EXP_ID;
      frm_value = CHIP_ID_EXPECT;
    end
  end

  // Required return word for the frame currently being received.
  always_comb begin
    check_en  = 1'b0;
    rx_expect = 16'd0;
    case (chk_kind_q)
      EXP_ECHO: begin
        check_en  = 1'b1;
        rx_expect = {8'hFF, chk_value_q};
      end
      EXP_ID: begin
        check_en  = 1'b1;
        rx_expect = {8'h00, chk_value_q};
      end
      default: ;
    endcase
  end

  assign rx_mismatch = check_en && (spi_rx != rx_expect);

  // Sequencer next-state; abort overrides everything, including a start in IDLE.
  always_comb begin
    state_d     = state_q;
    f_d         = f_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    chip_id_d   = chip_id_q;
    spi_start_d = 1'b0;
    spi_data_d  = spi_data_q;
    chk_kind_d  = chk_kind_q;
    chk_value_d = chk_value_q;
    pipe_clear  = 1'b0;
    pipe_push   = 1'b0;
    done_o      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          state_d     = ST_LOAD;
          f_d         = 8'd0;
          error_d     = 1'b0;
          err_index_d = 8'd0;
          pipe_clear  = 1'b1;
        end
      end
      ST_LOAD: begin
        spi_data_d = frm_cmd;
        if (!spi_done) begin
          state_d     = ST_TX;
          spi_start_d = 1'b1;
        end
      end
      ST_TX: begin
        chk_kind_d  = tap_kind;
        chk_value_d = tap_value;
        pipe_push   = 1'b1;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (spi_done) begin
          if (chk_kind_q == EXP_ID) begin
            chip_id_d = spi_rx[7:0];
          end
          if (rx_mismatch && !error_q) begin
            error_d     = 1'b1;
            err_index_d = f_q - 8'd2;
          end
          if (f_q == LAST_F) begin
            state_d    = ST_IDLE;
            done_o     = 1'b1;
            pipe_clear = 1'b1;
          end else begin
            f_d     = f_q + 8'd1;
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cfg_abort) begin
      state_d     = ST_IDLE;
      f_d         = f_q;
      error_d     = error_q;
      err_index_d = err_index_q;
      chip_id_d   = chip_id_q;
      spi_start_d = 1'b0;
      pipe_clear  = 1'b1;
      pipe_push   = 1'b0;
      done_o      = 1'b0;
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      f_q         <= 8'd0;
      error_q     <= 1'b0;
      err_index_q <= 8'd0;
      chip_id_q   <= 8'd0;
      spi_start_q <= 1'b0;
      spi_data_q  <= 16'd0;
      chk_kind_q  <= EXP_NONE;
      chk_value_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      f_q         <= f_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      chip_id_q   <= chip_id_d;
      spi_start_q <= spi_start_d;
      spi_data_q  <= spi_data_d;
      chk_kind_q  <= chk_kind_d;
      chk_value_q <= chk_value_d;
    end
  end

  rhd_expect_pipe u_expect_pipe (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (pipe_clear),
    .push       (pipe_push),
    .push_kind  (frm_kind),
    .push_value (frm_value),
    .tap_kind   (tap_kind),
    .tap_value  (tap_value)
  );

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_o;
  assign error       = error_q;
  assign err_index   = err_index_q;
  assign chip_id     = chip_id_q;
  assign spi_start   = spi_start_q;
  assign spi_data_in = spi_data_q;
  assign tbl_addr    = ((state_q != ST_IDLE) && (f_q < REGS_F)) ? f_q[5:0] : 6'd0;

endmodule

// File: tb/tb_rhd_config_seq.sv
// tb_rhd_config_seq: directed + randomized bench for rhd_config_seq with a
// behavioural RHD chip / SPI master model. Honours RHD_CAL_EN.
`timescale 1ns/1ps
module tb_rhd_config_seq;

`ifdef RHD_CAL_EN
  localparam int NR   = 18;
  localparam int CALF = 10;
`else
  localparam int NR   = 3;
  localparam int CALF = 0;
`endif
  localparam int         CD  = 9;
  localparam logic [7:0] CID = 8'd4;
  localparam int         NF  = NR + CALF + 3;
  localparam int         IDF = NR + CALF;
  localparam int         K_NONE = 0, K_ECHO = 1, K_ID = 2;

  logic        clk = 1'b0;
  logic        rstn, cfg_start, cfg_abort;
  logic        busy, done, error, spi_start, spi_done;
  logic [7:0]  err_index, chip_id, tbl_data;
  logic [5:0]  tbl_addr;
  logic [15:0] spi_data_in, spi_rx;

  rhd_config_seq #(.NUM_REGS(NR), .CHIP_ID_EXPECT(CID), .CAL_DUMMIES(CD)) dut (
    .clk(clk), .rstn(rstn), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .busy(busy), .done(done), .error(error), .err_index(err_index),
    .chip_id(chip_id), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .spi_start(spi_start), .spi_data_in(spi_data_in), .spi_done(spi_done),
    .spi_rx(spi_rx)
  );

  always #5 clk = ~clk;

  logic [7:0] tbl_mem [64];
  assign tbl_data = tbl_mem[tbl_addr];

  // ---------------- chip + SPI master model ----------------
  logic [7:0]  chip_reg63;
  int          corrupt_at;
  logic [15:0] corrupt_val;
  logic [15:0] cmd_log [$];
  logic [5:0]  addr_log [$];
  logic [15:0] rx_log [$];
  int          unstable;
  logic [15:0] h1, h2, pend;
  int          timer, hold;
  bit          in_frame;

  function automatic logic [15:0] chip_reply(input logic [15:0] c);
    if (c[15:14] == 2'b10) return {8'hFF, c[7:0]};
    if (c[15:14] == 2'b11 && c[13:8] == 6'd63) return {8'h00, chip_reg63};
    return 16'h0000;
  endfunction

  always @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      spi_done = 1'b0; spi_rx = 16'h0; in_frame = 0; hold = 0; timer = 0;
      h1 = 16'h0; h2 = 16'h0; pend = 16'h0;
    end else begin
      if (hold > 0) begin
        hold--;
        if (hold == 0) spi_done = 1'b0;
      end
      if (spi_start) begin
        spi_done = 1'b0; hold = 0;
        pend = (cmd_log.size() == corrupt_at) ? corrupt_val : chip_reply(h2);
        h2 = h1; h1 = spi_data_in;
        cmd_log.push_back(spi_data_in);
        addr_log.push_back(tbl_addr);
        timer = $urandom_range(1, 5);
        in_frame = 1;
      end else if (in_frame) begin
        timer--;
        if (timer == 0) begin
          in_frame = 0; spi_done = 1'b1; spi_rx = pend;
          rx_log.push_back(pend);
          if (spi_data_in !== cmd_log[$]) unstable++;
          hold = $urandom_range(1, 3);
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0, n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_error"}, error, 0);
    chk({nm, "_err_index"}, err_index, 0);
    chk({nm, "_chip_id"}, chip_id, 0);
    chk({nm, "_spi_start"}, spi_start, 0);
    chk({nm, "_spi_data_in"}, spi_data_in, 0);
    chk({nm, "_tbl_addr"}, tbl_addr, 0);
  endtask

  // Reference frame list built straight from the sequence definition.
  logic [15:0] exp_cmd [$];
  int          exp_kind [$];
  logic [7:0]  exp_val [$];
  logic [5:0]  exp_addr [$];

  task automatic build_expect();
    exp_cmd.delete(); exp_kind.delete(); exp_val.delete(); exp_addr.delete();
    for (int f = 0; f < NR; f++) begin
      exp_cmd.push_back({2'b10, 6'(f), tbl_mem[f]});
      exp_kind.push_back(K_ECHO); exp_val.push_back(tbl_mem[f]); exp_addr.push_back(6'(f));
    end
`ifdef RHD_CAL_EN
    exp_cmd.push_back(16'h5500); exp_kind.push_back(K_NONE); exp_val.push_back(8'h0); exp_addr.push_back(6'd0);
    for (int i = 0; i < CD; i++) begin
      exp_cmd.push_back(16'hFF00); exp_kind.push_back(K_NONE); exp_val.push_back(8'h0); exp_addr.push_back(6'd0);
    end
`endif
    exp_cmd.push_back(16'hFF00); exp_kind.push_back(K_ID); exp_val.push_back(CID); exp_addr.push_back(6'd0);
    for (int i = 0; i < 2; i++) begin
      exp_cmd.push_back(16'hFF00); exp_kind.push_back(K_NONE); exp_val.push_back(8'h0); exp_addr.push_back(6'd0);
    end
  endtask

  logic       e_err;
  logic [7:0] e_idx, e_cid;

  task automatic run_seq(input string nm, input int cf, input logic [15:0] cv, input bit start_mid);
    bit got_done, mid_sent, busy_at_done;
    int frames_at_done;
    got_done = 0; mid_sent = 0; busy_at_done = 0; frames_at_done = 0;
    repeat (20) tick();
    cmd_log.delete(); addr_log.delete(); rx_log.delete(); unstable = 0;
    corrupt_at = cf; corrupt_val = cv;
    build_expect();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk({nm, "_busy_n1"}, busy, 1);
    chk({nm, "_err_cleared"}, error, 0);
    tick();
    chk({nm, "_start_n2"}, spi_start, 1);
    for (int c = 0; c < 3000 && !got_done; c++) begin
      tick();
      if (start_mid && !mid_sent && cmd_log.size() == 2) begin
        cfg_start = 1'b1; mid_sent = 1;
      end else cfg_start = 1'b0;
      if (done) begin
        got_done = 1; busy_at_done = busy; frames_at_done = cmd_log.size();
      end
    end
    cfg_start = 1'b0;
    chk({nm, "_done_seen"}, got_done, 1);
    chk({nm, "_frames"}, frames_at_done, NF);
    chk({nm, "_busy_at_done"}, busy_at_done, 1);
    tick();
    chk({nm, "_done_one_cycle"}, done, 0);
    chk({nm, "_busy_fell"}, busy, 0);
    repeat (5) tick();
    chk({nm, "_no_restart"}, cmd_log.size(), NF);
    chk({nm, "_tbl_addr_idle"}, tbl_addr, 0);
    chk({nm, "_data_stable"}, unstable, 0);
    for (int f = 0; f < NF && f < cmd_log.size(); f++) begin
      chk($sformatf("%s_cmd%0d", nm, f), cmd_log[f], exp_cmd[f]);
      chk($sformatf("%s_addr%0d", nm, f), addr_log[f], exp_addr[f]);
    end
    e_err = 0; e_idx = 0; e_cid = 8'h0;
    for (int f = 2; f < rx_log.size() && f < NF; f++) begin
      bit bad;
      bad = 0;
      if (exp_kind[f-2] == K_ECHO) bad = (rx_log[f] != {8'hFF, exp_val[f-2]});
      if (exp_kind[f-2] == K_ID) begin
        e_cid = rx_log[f][7:0];
        bad = (rx_log[f] != {8'h00, CID});
      end
      if (bad && !e_err) begin e_err = 1; e_idx = 8'(f - 2); end
    end
    chk({nm, "_error"}, error, e_err);
    chk({nm, "_err_index"}, err_index, e_idx);
    chk({nm, "_chip_id"}, chip_id, e_cid);
  endtask

  initial begin
    logic [7:0] last_cid;
    rstn = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0;
    corrupt_at = -1; corrupt_val = 16'h0; chip_reg63 = 8'd4; unstable = 0;
    for (int i = 0; i < 64; i++) tbl_mem[i] = 8'($urandom);

    repeat (3) tick();
    chk_reset_vals("rst");
    rstn = 1'b1;

    // Clean run: all echoes correct, chip ID 4.
    run_seq("clean", -1, 16'h0, 0);
    chk("clean_error_const", error, 0);
    chk("clean_chip_id_const", chip_id, 8'd4);
`ifdef RHD_CAL_EN
    if (cmd_log.size() == NF) begin
      chk("cal_frame", cmd_log[NR], 16'h5500);
      for (int i = 1; i <= CD; i++) chk($sformatf("cal_dummy%0d", i), cmd_log[NR+i], 16'hFF00);
    end else chk("cal_frame_count", cmd_log.size(), NF);
`endif

    // Register 1 echo (returned in frame 3) corrupted.
    tbl_mem[1] = 8'h5A;
    run_seq("corr", 3, 16'hFF00, 0);
    chk("corr_error_const", error, 1);
    chk("corr_err_index_const", err_index, 8'd1);
    last_cid = e_cid;

    // Abort in WAIT of frame 5, with an error already latched at frame 3.
    repeat (20) tick();
    cmd_log.delete(); addr_log.delete(); rx_log.delete();
    corrupt_at = 3; corrupt_val = 16'h1234;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    begin
      bit reached;
      reached = 0;
      for (int c = 0; c < 2000 && !reached; c++) begin
        tick();
        if (cmd_log.size() == 6 && !spi_start) reached = 1;
      end
      chk("abort_reached_f5", reached, 1);
    end
    cfg_abort = 1'b1;
    #1;
    chk("abort_no_done", done, 0);
    tick();
    cfg_abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_spi_start", spi_start, 0);
    chk("abort_error_held", error, 1);
    chk("abort_err_index_held", err_index, 8'd1);
    chk("abort_chip_id_held", chip_id, last_cid);
    begin
      int dn;
      dn = 0;
      repeat (40) begin tick(); if (done) dn++; end
      chk("abort_done_count", dn, 0);
      chk("abort_no_more_frames", cmd_log.size(), 6);
    end

    // Restart after abort: frame 0 again, error cleared.
    run_seq("restart", -1, 16'h0, 0);

    // Start together with abort while idle: ignored.
    cfg_start = 1'b1; cfg_abort = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    tick();
    chk("start_abort_no_frame", spi_start, 0);

    // Randomized runs; one with a stray cfg_start mid-sequence.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 64; i++) tbl_mem[i] = 8'($urandom);
      chip_reg63 = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'd4;
      if ($urandom_range(0, 1) == 1)
        run_seq($sformatf("rnd%0d", r), $urandom_range(2, NF - 1), 16'($urandom), r == 1);
      else
        run_seq($sformatf("rnd%0d", r), -1, 16'h0, r == 1);
    end
    chip_reg63 = 8'd4;

    // Reset mid-frame: outputs return asynchronously.
    repeat (20) tick();
    cmd_log.delete(); addr_log.delete(); rx_log.delete(); corrupt_at = 3; corrupt_val = 16'hBEEF;
    cfg_start = 1'b1; tick(); cfg_start = 1'b0;
    begin
      bit reached;
      reached = 0;
      for (int c = 0; c < 2000 && !reached; c++) begin
        tick();
        if (cmd_log.size() == 5 && !spi_start) reached = 1;
      end
      chk("rst_mid_reached", reached, 1);
    end
    chk("rst_mid_busy_before", busy, 1);
    chk("rst_mid_error_before", error, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    repeat (2) tick();
    rstn = 1'b1;
    run_seq("after_rst", -1, 16'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
